// File: rtl/nmea_rx_decoder.sv
// NMEA receive path: 8N1 serial receiver plus "$body*HH\r\n" sentence framer and XOR checksum check.
// Latency: data_valid/sentence_ok/sentence_err one clk after stop-bit sample; no flow control.
module nmea_rx_decoder #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 4800,
    parameter int MAX_LEN  = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nmea_rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       sentence_ok,
    output logic       sentence_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int LW  = $clog2(MAX_LEN + 2);

    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(DIV - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [2:0] {D_WAIT, D_BODY, D_CK1, D_CK2, D_CR, D_LF, D_OK, D_ERR} dec_state_t;

    // ---------------- line synchroniser ----------------
    logic rx_meta, rx_sync, rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= nmea_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // ---------------- bit FSM ----------------
    bit_state_t    bstate, bstate_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          byte_stb;
    logic          fe_stb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bstate  <= B_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            bstate  <= bstate_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        bstate_nxt  = bstate;
        cnt_nxt     = cnt + 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_stb    = 1'b0;
        fe_stb      = 1'b0;
        case (bstate)
            B_IDLE: begin
                cnt_nxt = '0;
                if (rx_fall) bstate_nxt = B_START;
            end
            B_START: begin
                // Mid-start-bit resample rejects short glitches on the idle line.
                if (cnt == HALF_M1) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    bstate_nxt  = rx_sync ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_sync, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) bstate_nxt = B_STOP;
                end
            end
            B_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt    = '0;
                    bstate_nxt = B_IDLE;
                    byte_stb   = rx_sync;
                    fe_stb     = ~rx_sync;
                end
            end
            default: bstate_nxt = B_IDLE;
        endcase
    end

    // ---------------- sentence decoder ----------------
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
        return 5'b0;
    endfunction

    dec_state_t    dstate, dstate_nxt;
    logic [7:0]    csum, csum_nxt;
    logic [7:0]    rx_ck, rx_ck_nxt;
    logic [LW-1:0] len, len_nxt;
    logic [7:0]    data_nxt;
    logic          dv_nxt, err_nxt;
    logic          in_sent;
    logic [4:0]    hv;

    assign in_sent = (dstate == D_BODY) || (dstate == D_CK1) || (dstate == D_CK2) ||
                     (dstate == D_CR)   || (dstate == D_LF);
    assign hv      = hex_val(shreg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dstate       <= D_WAIT;
            csum         <= '0;
            rx_ck        <= '0;
            len          <= '0;
            data         <= '0;
            data_valid   <= 1'b0;
            sentence_ok  <= 1'b0;
            sentence_err <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            dstate       <= dstate_nxt;
            csum         <= csum_nxt;
            rx_ck        <= rx_ck_nxt;
            len          <= len_nxt;
            data         <= data_nxt;
            data_valid   <= dv_nxt;
            sentence_ok  <= (dstate_nxt == D_OK);
            sentence_err <= err_nxt;
            frame_err    <= fe_stb;
        end
    end

    always_comb begin
        dstate_nxt = dstate;
        csum_nxt   = csum;
        rx_ck_nxt  = rx_ck;
        len_nxt    = len;
        data_nxt   = data;
        dv_nxt     = 1'b0;
        err_nxt    = 1'b0;
        if (dstate == D_OK || dstate == D_ERR) dstate_nxt = D_WAIT;
        if (byte_stb) begin
            if (shreg == CH_DOLLAR) begin
                // A fresh '$' always restarts the sentence; an open one is reported as aborted.
                err_nxt    = in_sent;
                dstate_nxt = D_BODY;
                csum_nxt   = '0;
                len_nxt    = '0;
            end else begin
                case (dstate)
                    D_BODY: begin
                        if (shreg == CH_STAR) begin
                            dstate_nxt = D_CK1;
                        end else if (len == LEN_MAX) begin
                            dstate_nxt = D_ERR;
                        end else begin
                            csum_nxt = csum ^ shreg;
                            len_nxt  = len + 1'b1;
                            data_nxt = shreg;
                            dv_nxt   = 1'b1;
                        end
                    end
                    D_CK1: begin
                        rx_ck_nxt  = {hv[3:0], rx_ck[3:0]};
                        dstate_nxt = hv[4] ? D_CK2 : D_ERR;
                    end
                    D_CK2: begin
                        rx_ck_nxt  = {rx_ck[7:4], hv[3:0]};
                        dstate_nxt = hv[4] ? D_CR : D_ERR;
                    end
                    D_CR: dstate_nxt = (shreg == CH_CR) ? D_LF : D_ERR;
                    D_LF: begin
                        if (shreg == CH_LF && rx_ck == csum) dstate_nxt = D_OK;
                        else                                 dstate_nxt = D_ERR;
                    end
                    default: ;
                endcase
            end
        end
        if (fe_stb && in_sent) begin
            dstate_nxt = D_WAIT;
            err_nxt    = 1'b1;
        end
        if (dstate_nxt == D_ERR) err_nxt = 1'b1;
    end

    assign busy = in_sent;

endmodule
